decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage. Sits directly downstream of the fetch stage and upstream of execute.
- Consumes the fetched instruction and its PC and decodes RV32I into a registered decoded-instruction bundle.
- Reads the register file through external read ports, with a writeback bypass.
- Relays pipeline control (READY/STALL/JUMP) and the jump address backwards to fetch.

Parameters:
- None. Reset PC comes from constants::RESET_ADDRESS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instruction_in  in  32  fetched instruction
- program_counter_in  in  32  PC of instruction_in
- status_forwards_in  in  pipeline_status::forwards_t  from fetch (VALID/BUBBLE/FETCH_FAULT)
- status_backwards_out  out  pipeline_status::backwards_t  to fetch
- jump_address_backwards_out  out  32  to fetch
- rs1_address_out  out  5  register file read address 1 (combinational from instruction_in[19:15])
- rs2_address_out  out  5  register file read address 2 (instruction_in[24:20])
- rs1_data_in  in  32  register file read data 1
- rs2_data_in  in  32  register file read data 2
- wb_write_enable_in  in  1  writeback write this cycle
- wb_address_in  in  5  writeback rd
- wb_data_in  in  32  writeback data
- decoded_reg_out  out  decode_types::decoded_t  registered decoded fields (rd, rs1, rs2, funct3, alu_op, format, imm, flags)
- rs1_data_reg_out  out  32  registered operand 1
- rs2_data_reg_out  out  32  registered operand 2
- program_counter_reg_out  out  32  registered PC
- status_forwards_out  out  pipeline_status::forwards_t  to execute
- status_backwards_in  in  pipeline_status::backwards_t  from execute
- jump_address_backwards_in  in  32  from execute

Behaviour:
- Single clock clk; rst synchronous active-high.
- Reset values:
  - status_forwards_out = BUBBLE
  - decoded_reg_out = all zero (alu_op = ALU_ADD, all flags 0)
  - rs1_data_reg_out = rs2_data_reg_out = 0
  - program_counter_reg_out = RESET_ADDRESS
- Backwards path is purely combinational, zero latency:
  - status_backwards_out = status_backwards_in
  - jump_address_backwards_out = jump_address_backwards_in
- Register update at posedge clk, latency one cycle:
  - status_backwards_in == JUMP: status_forwards_out <= BUBBLE. Data registers don't-care (may hold).
  - status_backwards_in == STALL: all output registers hold.
  - status_backwards_in == READY: capture decode of instruction_in, program_counter_in, and the bypassed operands.
    - Forwarded status: VALID and legal -> VALID; VALID and illegal -> ILLEGAL_INSTRUCTION; FETCH_FAULT -> FETCH_FAULT; BUBBLE -> BUBBLE.
  - rst has priority over all of the above.
- Operand bypass:
  - rsN_data = wb_data_in when wb_write_enable_in && wb_address_in == rsN_address && wb_address_in != 0; otherwise rsN_data_in.
  - If the register number is 0, the operand is forced to 0 regardless of rsN_data_in.
- Immediates (sign-extended to 32 bits, per format):
  - I: [31:20]
  - S: [31:25|11:7]
  - B: [31|7|30:25|11:8|0]
  - U: [31:12]<<12
  - J: [31|19:12|20|30:21|0]
  - R: imm = 0
- Legality: bits[1:0] must be 2'b11, plus the per-opcode rules below. Anything else is illegal.
  - LUI, AUIPC, JAL: legal.
  - JALR: f3 = 000.
  - BRANCH: f3 not in {010, 011}.
  - LOAD: f3 in {000, 001, 010, 100, 101}.
  - STORE: f3 in {000, 001, 010}.
  - OP-IMM: SLLI needs f7 = 0; SRLI/SRAI need f7 in {0, 0100000}.
  - OP: f7 = 0, or f7 = 0100000 only with f3 in {000, 101}.
  - MISC-MEM: legal, decoded as NOP.
  - SYSTEM: f3 = 000 with instr[31:7] = 0 (ECALL) or imm = 1 (EBREAK); f3 in {001, 010, 011, 101, 110, 111} (CSR).
- Illegal instructions: all writeback/memory/branch flags are cleared (no side effects).
- Flags: reg_write (rd != 0 for writing formats), mem_read, mem_write, branch, jump, csr, ecall, ebreak.
- No internal state beyond the output registers. No FSM; the pipeline handshake is the only control.

Decomposition:
- pipeline_status package: add ILLEGAL_INSTRUCTION to forwards_t.
- New package decode_types, containing:
  - opcode localparams
  - format_t enum: R/I/S/B/U/J
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
  - decoded_t packed struct
- One sub-module: imm_gen (instruction + format_t -> 32-bit immediate), purely combinational.

Test Plan:
- Reset held 2 cycles -> status_forwards_out = BUBBLE, rs1_data_reg_out = 0, program_counter_reg_out = RESET_ADDRESS.
- VALID 0x00500093 (addi x1,x0,5), PC 0x100, READY -> next cycle VALID, rd = 1, rs1 = 0, imm = 5, alu_op = ADD, reg_write = 1, rs1_data_reg_out = 0 even with rs1_data_in = 0xFFFFFFFF.
- Same instruction with STALL for 3 cycles, then new instruction input -> outputs unchanged during stall; status_backwards_out = STALL each cycle.
- JUMP with jump_address_backwards_in = 0x200 -> combinationally status_backwards_out = JUMP and jump_address_backwards_out = 0x200; next cycle status_forwards_out = BUBBLE.
- VALID 0x00000000 -> ILLEGAL_INSTRUCTION with reg_write = 0; FETCH_FAULT input -> FETCH_FAULT output.
- VALID 0x00528333 (add x6,x5,x5), wb write x5 = 0xDEADBEEF in the same cycle, rs1_data_in = rs2_data_in = 0x0 -> both operand registers = 0xDEADBEEF. A wb write to x0 must not bypass.

Source files
------------

// File: rtl/constants.sv
// Project-wide constants shared by the pipeline stages.
package constants;

  localparam logic [31:0] RESET_ADDRESS = 32'h8000_0000;

endpackage

// File: rtl/decode_types.sv
// RV32I decode types: opcodes, instruction formats, ALU operations and the
// decoded-instruction bundle handed from decode to execute.
package decode_types;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } format_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    format_t     format;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        csr;
    logic        ecall;
    logic        ebreak;
  } decoded_t;

  // Shared OP / OP-IMM ALU selection; alt selects SUB/SRA variants.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_status.sv
// Pipeline handshake encodings. Forward status travels toward execute;
// backward status travels toward fetch.
package pipeline_status;

  typedef enum logic [1:0] {
    VALID               = 2'd0,
    BUBBLE              = 2'd1,
    FETCH_FAULT         = 2'd2,
    ILLEGAL_INSTRUCTION = 2'd3
  } forwards_t;

  typedef enum logic [1:0] {
    READY = 2'd0,
    STALL = 2'd1,
    JUMP  = 2'd2
  } backwards_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of an RV32I
// instruction according to its format. Purely combinational.
//   instruction_i : raw 32-bit instruction
//   format_i      : decoded instruction format
//   imm_c_o       : 32-bit immediate (zero for R format)
module imm_gen
  import decode_types::*;
(
  input  logic [31:0] instruction_i,
  input  format_t     format_i,
  output logic [31:0] imm_c_o
);

  always_comb begin
    imm_c_o = '0;
    case (format_i)
      FMT_I:   imm_c_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
      FMT_S:   imm_c_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      FMT_B:   imm_c_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                          instruction_i[30:25], instruction_i[11:8], 1'b0};
      FMT_U:   imm_c_o = {instruction_i[31:12], 12'b0};
      FMT_J:   imm_c_o = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                          instruction_i[20], instruction_i[30:21], 1'b0};
      default: imm_c_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage. Decodes the fetched instruction into a registered
// bundle, reads operands (with writeback bypass) and relays the backward
// pipeline control to fetch.
//   clk, rst                    : clock, synchronous active-high reset
//   instruction_in, program_counter_in, status_forwards_in : from fetch
//   status_backwards_out, jump_address_backwards_out       : to fetch (combinational)
//   rs1/rs2_address_out, rs1/rs2_data_in                   : register file read ports
//   wb_write_enable_in, wb_address_in, wb_data_in          : writeback bypass
//   decoded_reg_out, rs1/rs2_data_reg_out, program_counter_reg_out,
//   status_forwards_out                                    : registered, to execute
//   status_backwards_in, jump_address_backwards_in         : from execute
module decode_stage
  import pipeline_status::*;
  import decode_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_in,
  input  logic [31:0] program_counter_in,
  input  forwards_t   status_forwards_in,
  output backwards_t  status_backwards_out,
  output logic [31:0] jump_address_backwards_out,
  output logic [4:0]  rs1_address_out,
  output logic [4:0]  rs2_address_out,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic        wb_write_enable_in,
  input  logic [4:0]  wb_address_in,
  input  logic [31:0] wb_data_in,
  output decoded_t    decoded_reg_out,
  output logic [31:0] rs1_data_reg_out,
  output logic [31:0] rs2_data_reg_out,
  output logic [31:0] program_counter_reg_out,
  output forwards_t   status_forwards_out,
  input  backwards_t  status_backwards_in,
  input  logic [31:0] jump_address_backwards_in
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;

  assign opcode = instruction_in[6:0];
  assign f3     = instruction_in[14:12];
  assign f7     = instruction_in[31:25];
  assign rd     = instruction_in[11:7];

  // Backward path is a zero-latency relay.
  assign status_backwards_out       = status_backwards_in;
  assign jump_address_backwards_out = jump_address_backwards_in;

  assign rs1_address_out = instruction_in[19:15];
  assign rs2_address_out = instruction_in[24:20];

  // Operand selection: x0 reads as zero, otherwise writeback data wins.
  logic [31:0] rs1_op_c, rs2_op_c;
  always_comb begin
    rs1_op_c = rs1_data_in;
    rs2_op_c = rs2_data_in;
    if (rs1_address_out == 5'd0) begin
      rs1_op_c = '0;
    end else if (wb_write_enable_in && wb_address_in == rs1_address_out) begin
      rs1_op_c = wb_data_in;
    end
    if (rs2_address_out == 5'd0) begin
      rs2_op_c = '0;
    end else if (wb_write_enable_in && wb_address_in == rs2_address_out) begin
      rs2_op_c = wb_data_in;
    end
  end

  // Opcode decode: format, ALU op, legality and side-effect flags.
  format_t     fmt_c;
  alu_op_t     alu_c;
  logic        legal_c, writes_rd_c, mem_read_c, mem_write_c;
  logic        branch_c, jump_c, csr_c, ecall_c, ebreak_c;
  logic [31:0] imm_c;

  always_comb begin
    fmt_c       = FMT_R;
    alu_c       = ALU_ADD;
    legal_c     = 1'b0;
    writes_rd_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    branch_c    = 1'b0;
    jump_c      = 1'b0;
    csr_c       = 1'b0;
    ecall_c     = 1'b0;
    ebreak_c    = 1'b0;
    if (instruction_in[1:0] == 2'b11) begin
      case (opcode)
        OPC_LUI: begin
          fmt_c = FMT_U; alu_c = ALU_PASS_B; legal_c = 1'b1; writes_rd_c = 1'b1;
        end
        OPC_AUIPC: begin
          fmt_c = FMT_U; legal_c = 1'b1; writes_rd_c = 1'b1;
        end
        OPC_JAL: begin
          fmt_c = FMT_J; legal_c = 1'b1; writes_rd_c = 1'b1; jump_c = 1'b1;
        end
        OPC_JALR: begin
          fmt_c = FMT_I; legal_c = (f3 == 3'b000); writes_rd_c = 1'b1; jump_c = 1'b1;
        end
        OPC_BRANCH: begin
          fmt_c = FMT_B; legal_c = (f3 != 3'b010) && (f3 != 3'b011); branch_c = 1'b1;
        end
        OPC_LOAD: begin
          fmt_c = FMT_I; legal_c = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
          writes_rd_c = 1'b1; mem_read_c = 1'b1;
        end
        OPC_STORE: begin
          fmt_c = FMT_S; legal_c = f3 inside {3'b000, 3'b001, 3'b010}; mem_write_c = 1'b1;
        end
        OPC_OP_IMM: begin
          fmt_c = FMT_I; writes_rd_c = 1'b1;
          // Only the shift-right encoding carries an arithmetic variant.
          alu_c = alu_from_f3(f3, f7[5] && (f3 == 3'b101));
          case (f3)
            3'b001:  legal_c = (f7 == F7_ZERO);
            3'b101:  legal_c = (f7 == F7_ZERO) || (f7 == F7_ALT);
            default: legal_c = 1'b1;
          endcase
        end
        OPC_OP: begin
          fmt_c = FMT_R; writes_rd_c = 1'b1;
          alu_c = alu_from_f3(f3, f7[5]);
          legal_c = (f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
        end
        OPC_MISC_MEM: begin
          fmt_c = FMT_I; legal_c = 1'b1;
        end
        OPC_SYSTEM: begin
          fmt_c = FMT_I;
          if (f3 == 3'b000) begin
            ecall_c  = (instruction_in[31:7] == 25'd0);
            ebreak_c = (instruction_in[31:20] == 12'd1) && (instruction_in[19:7] == 13'd0);
            legal_c  = ecall_c || ebreak_c;
          end else begin
            legal_c = (f3 != 3'b100); csr_c = 1'b1; writes_rd_c = 1'b1;
          end
        end
        default: legal_c = 1'b0;
      endcase
    end
  end

  imm_gen u_imm_gen (
    .instruction_i (instruction_in),
    .format_i      (fmt_c),
    .imm_c_o       (imm_c)
  );

  decoded_t    decoded_d, decoded_q;
  logic [31:0] rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, pc_d, pc_q;
  forwards_t   status_d, status_q;

  // Next-state: hold by default, bubble on jump, capture on ready.
  always_comb begin
    decoded_d  = decoded_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    pc_d       = pc_q;
    status_d   = status_q;
    case (status_backwards_in)
      JUMP: status_d = BUBBLE;
      READY: begin
        decoded_d.rd        = rd;
        decoded_d.rs1       = rs1_address_out;
        decoded_d.rs2       = rs2_address_out;
        decoded_d.funct3    = f3;
        decoded_d.alu_op    = alu_c;
        decoded_d.format    = fmt_c;
        decoded_d.imm       = imm_c;
        // Illegal instructions must not cause any architectural side effect.
        decoded_d.reg_write = legal_c && writes_rd_c && (rd != 5'd0);
        decoded_d.mem_read  = legal_c && mem_read_c;
        decoded_d.mem_write = legal_c && mem_write_c;
        decoded_d.branch    = legal_c && branch_c;
        decoded_d.jump      = legal_c && jump_c;
        decoded_d.csr       = legal_c && csr_c;
        decoded_d.ecall     = legal_c && ecall_c;
        decoded_d.ebreak    = legal_c && ebreak_c;
        rs1_data_d          = rs1_op_c;
        rs2_data_d          = rs2_op_c;
        pc_d                = program_counter_in;
        if (status_forwards_in == VALID) begin
          status_d = legal_c ? VALID : ILLEGAL_INSTRUCTION;
        end else begin
          status_d = status_forwards_in;
        end
      end
      default: status_d = status_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decoded_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      pc_q       <= constants::RESET_ADDRESS;
      status_q   <= BUBBLE;
    end else begin
      decoded_q  <= decoded_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      pc_q       <= pc_d;
      status_q   <= status_d;
    end
  end

  assign decoded_reg_out         = decoded_q;
  assign rs1_data_reg_out        = rs1_data_q;
  assign rs2_data_reg_out        = rs2_data_q;
  assign program_counter_reg_out = pc_q;
  assign status_forwards_out     = status_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
  import pipeline_status::*;
  import decode_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_in, program_counter_in;
  forwards_t   status_forwards_in, status_forwards_out;
  backwards_t  status_backwards_out, status_backwards_in;
  logic [31:0] jump_address_backwards_out, jump_address_backwards_in;
  logic [4:0]  rs1_address_out, rs2_address_out, wb_address_in;
  logic [31:0] rs1_data_in, rs2_data_in, wb_data_in;
  logic        wb_write_enable_in;
  decoded_t    decoded_reg_out;
  logic [31:0] rs1_data_reg_out, rs2_data_reg_out, program_counter_reg_out;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk                        (clk),
    .rst                        (rst),
    .instruction_in             (instruction_in),
    .program_counter_in         (program_counter_in),
    .status_forwards_in         (status_forwards_in),
    .status_backwards_out       (status_backwards_out),
    .jump_address_backwards_out (jump_address_backwards_out),
    .rs1_address_out            (rs1_address_out),
    .rs2_address_out            (rs2_address_out),
    .rs1_data_in                (rs1_data_in),
    .rs2_data_in                (rs2_data_in),
    .wb_write_enable_in         (wb_write_enable_in),
    .wb_address_in              (wb_address_in),
    .wb_data_in                 (wb_data_in),
    .decoded_reg_out            (decoded_reg_out),
    .rs1_data_reg_out           (rs1_data_reg_out),
    .rs2_data_reg_out           (rs2_data_reg_out),
    .program_counter_reg_out    (program_counter_reg_out),
    .status_forwards_out        (status_forwards_out),
    .status_backwards_in        (status_backwards_in),
    .jump_address_backwards_in  (jump_address_backwards_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input forwards_t fwd);
    instruction_in     = instr;
    program_counter_in = pc;
    status_forwards_in = fwd;
  endtask

  initial begin
    rst                       = 1'b1;
    status_backwards_in       = READY;
    jump_address_backwards_in = 32'h0;
    rs1_data_in               = 32'h0;
    rs2_data_in               = 32'h0;
    wb_write_enable_in        = 1'b0;
    wb_address_in             = 5'd0;
    wb_data_in                = 32'h0;
    apply(32'h00500093, 32'h0000_0040, VALID);
    tick();
    tick();
    check("rst_status", 32'(status_forwards_out), 32'(BUBBLE));
    check("rst_rs1", rs1_data_reg_out, 32'h0);
    check("rst_rs2", rs2_data_reg_out, 32'h0);
    check("rst_pc", program_counter_reg_out, 32'h8000_0000);
    check("rst_imm", decoded_reg_out.imm, 32'h0);
    check("rst_alu", 32'(decoded_reg_out.alu_op), 32'(ALU_ADD));
    check("rst_regwr", 32'(decoded_reg_out.reg_write), 32'h0);

    // addi x1,x0,5: x0 operand forced to zero despite nonzero read data
    rst = 1'b0;
    apply(32'h00500093, 32'h0000_0100, VALID);
    rs1_data_in = 32'hFFFF_FFFF;
    rs2_data_in = 32'h1234_5678;
    #1;
    check("rs1_addr_comb", 32'(rs1_address_out), 32'd0);
    check("rs2_addr_comb", 32'(rs2_address_out), 32'd5);
    tick();
    check("addi_status", 32'(status_forwards_out), 32'(VALID));
    check("addi_rd", 32'(decoded_reg_out.rd), 32'd1);
    check("addi_rs1", 32'(decoded_reg_out.rs1), 32'd0);
    check("addi_imm", decoded_reg_out.imm, 32'd5);
    check("addi_alu", 32'(decoded_reg_out.alu_op), 32'(ALU_ADD));
    check("addi_fmt", 32'(decoded_reg_out.format), 32'(FMT_I));
    check("addi_regwr", 32'(decoded_reg_out.reg_write), 32'd1);
    check("addi_rs1_data", rs1_data_reg_out, 32'h0);
    check("addi_rs2_data", rs2_data_reg_out, 32'h1234_5678);
    check("addi_pc", program_counter_reg_out, 32'h0000_0100);

    // Stall: new inputs must not be captured
    status_backwards_in = STALL;
    #1;
    check("stall_back_comb", 32'(status_backwards_out), 32'(STALL));
    apply(32'h00528333, 32'h0000_0104, VALID);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_back", 32'(status_backwards_out), 32'(STALL));
      check("stall_pc", program_counter_reg_out, 32'h0000_0100);
      check("stall_rd", 32'(decoded_reg_out.rd), 32'd1);
      check("stall_status", 32'(status_forwards_out), 32'(VALID));
    end

    // Jump: combinational relay, then a bubble forward
    status_backwards_in       = JUMP;
    jump_address_backwards_in = 32'h0000_0200;
    #1;
    check("jump_back_comb", 32'(status_backwards_out), 32'(JUMP));
    check("jump_addr_comb", jump_address_backwards_out, 32'h0000_0200);
    tick();
    check("jump_status", 32'(status_forwards_out), 32'(BUBBLE));

    // All-zero instruction is illegal and has no side effects
    status_backwards_in = READY;
    apply(32'h0000_0000, 32'h0000_0108, VALID);
    tick();
    check("zero_status", 32'(status_forwards_out), 32'(ILLEGAL_INSTRUCTION));
    check("zero_regwr", 32'(decoded_reg_out.reg_write), 32'd0);

    // Fetch fault passes through
    apply(32'h00500093, 32'h0000_010C, FETCH_FAULT);
    tick();
    check("ff_status", 32'(status_forwards_out), 32'(FETCH_FAULT));
    check("ff_pc", program_counter_reg_out, 32'h0000_010C);

    // Bubble passes through
    apply(32'h00500093, 32'h0000_0110, BUBBLE);
    tick();
    check("bubble_status", 32'(status_forwards_out), 32'(BUBBLE));

    // add x6,x5,x5 with writeback of x5 in the same cycle
    apply(32'h00528333, 32'h0000_0114, VALID);
    rs1_data_in        = 32'h0;
    rs2_data_in        = 32'h0;
    wb_write_enable_in = 1'b1;
    wb_address_in      = 5'd5;
    wb_data_in         = 32'hDEAD_BEEF;
    tick();
    check("byp_rs1", rs1_data_reg_out, 32'hDEAD_BEEF);
    check("byp_rs2", rs2_data_reg_out, 32'hDEAD_BEEF);
    check("byp_rd", 32'(decoded_reg_out.rd), 32'd6);
    check("byp_fmt", 32'(decoded_reg_out.format), 32'(FMT_R));
    check("byp_imm", decoded_reg_out.imm, 32'h0);
    check("byp_regwr", 32'(decoded_reg_out.reg_write), 32'd1);

    // Writeback to another register does not bypass
    rs1_data_in   = 32'h0000_0011;
    rs2_data_in   = 32'h0000_0022;
    wb_address_in = 5'd7;
    tick();
    check("nobyp_rs1", rs1_data_reg_out, 32'h0000_0011);
    check("nobyp_rs2", rs2_data_reg_out, 32'h0000_0022);

    // Writeback to x0 never bypasses: add x0,x0,x0
    apply(32'h0000_0033, 32'h0000_0118, VALID);
    wb_address_in = 5'd0;
    rs1_data_in   = 32'h0000_0055;
    tick();
    check("x0_rs1", rs1_data_reg_out, 32'h0);
    check("x0_regwr", 32'(decoded_reg_out.reg_write), 32'd0);
    wb_write_enable_in = 1'b0;

    // sub x3,x1,x2
    apply(32'h402081B3, 32'h0000_011C, VALID);
    tick();
    check("sub_alu", 32'(decoded_reg_out.alu_op), 32'(ALU_SUB));
    check("sub_status", 32'(status_forwards_out), 32'(VALID));

    // sw x2,-4(x1)
    apply(32'hFE20AE23, 32'h0000_0120, VALID);
    tick();
    check("sw_imm", decoded_reg_out.imm, 32'hFFFF_FFFC);
    check("sw_memwr", 32'(decoded_reg_out.mem_write), 32'd1);
    check("sw_regwr", 32'(decoded_reg_out.reg_write), 32'd0);

    // beq x1,x2,-8
    apply(32'hFE208CE3, 32'h0000_0124, VALID);
    tick();
    check("beq_imm", decoded_reg_out.imm, 32'hFFFF_FFF8);
    check("beq_branch", 32'(decoded_reg_out.branch), 32'd1);

    // lui x5,0x12345
    apply(32'h123452B7, 32'h0000_0128, VALID);
    tick();
    check("lui_imm", decoded_reg_out.imm, 32'h1234_5000);
    check("lui_alu", 32'(decoded_reg_out.alu_op), 32'(ALU_PASS_B));

    // jal x1,+2048
    apply(32'h001000EF, 32'h0000_012C, VALID);
    tick();
    check("jal_imm", decoded_reg_out.imm, 32'h0000_0800);
    check("jal_jump", 32'(decoded_reg_out.jump), 32'd1);

    // ecall / ebreak
    apply(32'h0000_0073, 32'h0000_0130, VALID);
    tick();
    check("ecall_flag", 32'(decoded_reg_out.ecall), 32'd1);
    apply(32'h0010_0073, 32'h0000_0134, VALID);
    tick();
    check("ebreak_flag", 32'(decoded_reg_out.ebreak), 32'd1);
    check("ebreak_status", 32'(status_forwards_out), 32'(VALID));

    // slli with funct7=0100000 is illegal
    apply(32'h40109093, 32'h0000_0138, VALID);
    tick();
    check("slli_bad_status", 32'(status_forwards_out), 32'(ILLEGAL_INSTRUCTION));
    check("slli_bad_regwr", 32'(decoded_reg_out.reg_write), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
